block_lock_ctrl: RTL and testbench
==================================

BLOCK_LOCK_CTRL -- requirements
Module: block_lock_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 32: consecutive valid headers at a stable offset needed to declare lock.
REQ-002 SHALL have parameter WIN_LEN, default 64: length of the monitoring window while locked, in header beats.
REQ-003 SHALL have parameter BAD_MAX, default 16: invalid headers within one window that force loss of lock.
REQ-004 SHALL have port clk_i, input, 1: single clock; every register is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port en_i, input, 1: controller enable; low holds the block in IDLE.
REQ-007 SHALL have port hdr_dv_i, input, 1: one-cycle strobe per 66b block; header_i and offset_i are sampled only when it is high.
REQ-008 SHALL have port offset_i, input, 7: candidate header offset from the block-sync search, range 0-65.
REQ-009 SHALL have port header_i, input, 2: the two header bits at the offset currently applied.
REQ-010 SHALL have port locked_o, output, 1: high while in LOCKED.
REQ-011 SHALL have port offset_o, output, 7: offset applied to the gearbox, frozen while locked.
REQ-012 SHALL have port rescan_o, output, 1: one-cycle pulse telling block sync to clear its counters.
REQ-013 SHALL have port loss_cnt_o, output, 8: saturating count of lock-loss events.

Function
REQ-014 SHALL treat a header as valid only when header_i is 2'b01 or 2'b10; 00 and 11 are invalid.
REQ-015 SHALL implement the states IDLE, HUNT, LOCKED and SLIP, with state and output registers only and no combinational input-to-output path.
REQ-016 IDLE: when en_i is high, SHALL go to HUNT on the next cycle and pulse rescan_o in that same transition cycle.
REQ-017 en_i low in any state SHALL return the block to IDLE on the next edge, with locked_o=0 and all counters cleared; loss_cnt_o is not cleared.
REQ-018 HUNT, each hdr_dv_i beat: if offset_i differs from offset_o, the block SHALL load offset_o<=offset_i and set good_cnt to 1 if the header is valid, else 0.
REQ-019 HUNT, same offset, valid header: the block SHALL increment good_cnt.
REQ-020 HUNT, same offset, invalid header: the block SHALL set good_cnt to 0.
REQ-021 HUNT: on the beat where good_cnt would reach LOCK_CNT, the block SHALL enter LOCKED, and locked_o SHALL go high on the cycle after that beat.
REQ-022 LOCKED: the block SHALL ignore offset_i and hold offset_o constant.
REQ-023 LOCKED: each beat SHALL increment win_cnt, and each invalid header SHALL increment bad_cnt.
REQ-024 LOCKED: when bad_cnt would reach BAD_MAX, the block SHALL enter SLIP, drop locked_o on the next cycle, and increment loss_cnt_o, saturating at 255.
REQ-025 LOCKED: after the WIN_LEN-th beat of a window, win_cnt and bad_cnt SHALL both clear to 0.
REQ-026 If the BAD_MAX condition and the window end fall on the same beat, the BAD_MAX condition SHALL take priority and the block SHALL enter SLIP.
REQ-027 SLIP: the block SHALL assert rescan_o for exactly one cycle, clear good_cnt, win_cnt and bad_cnt, and go to HUNT on the next cycle.
REQ-028 SLIP: hdr_dv_i beats arriving while in SLIP SHALL be discarded.
REQ-029 Beats with hdr_dv_i low SHALL change no counter and no state, except the en_i transitions.
REQ-030 Counter widths SHALL be sized to hold LOCK_CNT and WIN_LEN with no wrap-around.

Reset
REQ-031 When rst_i is asserted, at any time and in any state, the block SHALL immediately enter IDLE with locked_o=0, offset_o=0, rescan_o=0, loss_cnt_o=0 and all internal counters at 0.
REQ-032 After rst_i deasserts, the block SHALL leave IDLE on the first clock edge with en_i high.

Verification
REQ-033 Lock acquisition: en_i=1, offset_i=17, 32 beats of header 01/10 -> locked_o=1 one cycle after beat 32, offset_o=17.
REQ-034 Hunt restart on bad header: 31 valid beats, then header 11, then 31 valid beats -> locked_o stays 0; one further valid beat -> lock.
REQ-035 Hunt restart on offset change: offset_i changes 17 to 40 after 20 valid beats -> offset_o=40, lock only after 32 more valid beats.
REQ-036 Window reset keeps lock: while locked, 15 invalid headers in window 1, then 15 invalid in window 2 -> locked_o stays 1, loss_cnt_o=0.
REQ-037 Loss of lock: while locked, 16 invalid headers within 64 beats, the 16th on beat 64 -> SLIP, rescan_o high for exactly 1 cycle, locked_o=0, loss_cnt_o=1, then HUNT.
REQ-038 Reset mid-operation: rst_i pulsed while locked with loss_cnt_o=3 -> all outputs 0 with no clock edge needed; after release, rescan_o pulses on the first edge with en_i=1.

Source files
------------

// File: rtl/block_lock_ctrl_if.sv
// Block-lock controller bus: header beats in, lock status / applied offset out.
// Latency: n/a (signal bundle only).
// Backpressure: none; header beats are strobes and are never stalled.
interface block_lock_ctrl_if;
  logic       en_i;
  logic       hdr_dv_i;
  logic [6:0] offset_i;
  logic [1:0] header_i;
  logic       locked_o;
  logic [6:0] offset_o;
  logic       rescan_o;
  logic [7:0] loss_cnt_o;

  // Drives beats and enable, observes lock status.
  modport master (
    output en_i, hdr_dv_i, offset_i, header_i,
    input  locked_o, offset_o, rescan_o, loss_cnt_o
  );

  // The controller itself.
  modport slave (
    input  en_i, hdr_dv_i, offset_i, header_i,
    output locked_o, offset_o, rescan_o, loss_cnt_o
  );
endinterface

// File: rtl/block_lock_ctrl.sv
// 66b block-lock controller: hunts for a stable header offset, declares lock, monitors windows for loss.
// Latency: all outputs registered; locked_o/rescan_o change one cycle after the deciding beat.
// Backpressure: none; beats arriving during SLIP are dropped, beats with hdr_dv_i low are ignored.
module block_lock_ctrl #(
  parameter int LOCK_CNT = 32,
  parameter int WIN_LEN  = 64,
  parameter int BAD_MAX  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  block_lock_ctrl_if.slave bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int BW = $clog2(BAD_MAX + 1);

  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_V  = WW'(WIN_LEN);
  localparam logic [BW-1:0] BAD_V  = BW'(BAD_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOCKED,
    ST_SLIP
  } state_t;

  state_t        r_state;
  logic          r_locked;
  logic [6:0]    r_offset;
  logic          r_rescan;
  logic [7:0]    r_loss_cnt;
  logic [GW-1:0] r_good_cnt;
  logic [WW-1:0] r_win_cnt;
  logic [BW-1:0] r_bad_cnt;

  logic          w_hdr_ok;
  logic          w_new_off;
  logic [GW-1:0] w_good_nxt;
  logic [WW-1:0] w_win_nxt;
  logic [BW-1:0] w_bad_nxt;

  // Sync header is valid only for 01/10, i.e. when the two bits differ.
  assign w_hdr_ok  = bus.header_i[1] ^ bus.header_i[0];
  assign w_new_off = (bus.offset_i != r_offset);
  assign w_win_nxt = r_win_cnt + WW'(1);

  // Next-value candidates for the hunt and window counters on the current beat.
  always_comb begin
    w_good_nxt = r_good_cnt + GW'(1);
    if (w_new_off || !w_hdr_ok) begin
      w_good_nxt = w_hdr_ok ? GW'(1) : '0;
    end
    w_bad_nxt = w_hdr_ok ? r_bad_cnt : r_bad_cnt + BW'(1);
  end

  // Lock state machine; every output is a register written here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_locked   <= 1'b0;
      r_offset   <= '0;
      r_rescan   <= 1'b0;
      r_loss_cnt <= '0;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_rescan <= 1'b0;
      if (!bus.en_i) begin
        r_state    <= ST_IDLE;
        r_locked   <= 1'b0;
        r_good_cnt <= '0;
        r_win_cnt  <= '0;
        r_bad_cnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_HUNT;
            r_rescan <= 1'b1;
          end
          ST_HUNT: begin
            if (bus.hdr_dv_i) begin
              // Loading unconditionally equals loading only on a change.
              r_offset <= bus.offset_i;
              if (w_good_nxt == LOCK_V) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_good_cnt <= '0;
                r_win_cnt  <= '0;
                r_bad_cnt  <= '0;
              end else begin
                r_good_cnt <= w_good_nxt;
              end
            end
          end
          ST_LOCKED: begin
            if (bus.hdr_dv_i) begin
              // Too many bad headers wins over a window boundary on the same beat.
              if (w_bad_nxt == BAD_V) begin
                r_state    <= ST_SLIP;
                r_locked   <= 1'b0;
                r_rescan   <= 1'b1;
                r_win_cnt  <= '0;
                r_bad_cnt  <= '0;
                if (r_loss_cnt != 8'hFF) begin
                  r_loss_cnt <= r_loss_cnt + 8'd1;
                end
              end else if (w_win_nxt == WIN_V) begin
                r_win_cnt <= '0;
                r_bad_cnt <= '0;
              end else begin
                r_win_cnt <= w_win_nxt;
                r_bad_cnt <= w_bad_nxt;
              end
            end
          end
          ST_SLIP: begin
            r_state    <= ST_HUNT;
            r_good_cnt <= '0;
            r_win_cnt  <= '0;
            r_bad_cnt  <= '0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.locked_o   = r_locked;
  assign bus.offset_o   = r_offset;
  assign bus.rescan_o   = r_rescan;
  assign bus.loss_cnt_o = r_loss_cnt;

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Bench for block_lock_ctrl: vector table for lock acquisition, hand sequences for windows, loss, reset.
// Latency: expectations are queued when a cycle is driven and checked just after the next rising edge.
// Backpressure: none.
module tb_block_lock_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  block_lock_ctrl_if bus();

  block_lock_ctrl #(
    .LOCK_CNT(32),
    .WIN_LEN (64),
    .BAD_MAX (16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  typedef struct {
    logic       en;
    logic       dv;
    logic [6:0] off;
    logic [1:0] hdr;
    logic       e_lock;
    logic [6:0] e_off;
    logic       e_resc;
    logic [7:0] e_loss;
  } vec_t;

  typedef struct {
    logic [16:0] exp_v;
    string       tag;
  } exp_t;

  exp_t  sb[$];
  vec_t  tbl[$];
  int    checks   = 0;
  int    failures = 0;
  string cur_tag  = "init";

  function automatic logic [16:0] pack(input logic l, input logic [6:0] o,
                                       input logic r, input logic [7:0] c);
    return {l, o, r, c};
  endfunction

  function automatic logic [16:0] dut_out();
    return {bus.locked_o, bus.offset_o, bus.rescan_o, bus.loss_cnt_o};
  endfunction

  function automatic logic [1:0] good_hdr(input int k);
    return (k % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr(input int k);
    return (k % 2 == 1) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? 8'hFF : c + 8'd1;
  endfunction

  function automatic vec_t mk(input logic en, input logic dv, input logic [6:0] off,
                              input logic [1:0] hdr, input logic el, input logic [6:0] eo,
                              input logic er, input logic [7:0] ec);
    vec_t v;
    v.en = en; v.dv = dv; v.off = off; v.hdr = hdr;
    v.e_lock = el; v.e_off = eo; v.e_resc = er; v.e_loss = ec;
    return v;
  endfunction

  task automatic compare(input string tag, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got lock=%0b off=%0d rescan=%0b loss=%0d, want lock=%0b off=%0d rescan=%0b loss=%0d",
               tag, act[16], act[15:9], act[8], act[7:0], exp[16], exp[15:9], exp[8], exp[7:0]);
    end
  endtask

  // Scoreboard: pop the expectation for the edge that just happened.
  always @(posedge clk_i) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      compare(e.tag, dut_out(), e.exp_v);
    end
  end

  task automatic push_exp(input logic el, input logic [6:0] eo, input logic er, input logic [7:0] ec);
    exp_t e;
    e.exp_v = pack(el, eo, er, ec);
    e.tag   = cur_tag;
    sb.push_back(e);
  endtask

  task automatic step(input logic en, input logic dv, input logic [6:0] off, input logic [1:0] hdr,
                      input logic el, input logic [6:0] eo, input logic er, input logic [7:0] ec);
    @(negedge clk_i);
    bus.en_i     = en;
    bus.hdr_dv_i = dv;
    bus.offset_i = off;
    bus.header_i = hdr;
    push_exp(el, eo, er, ec);
    @(posedge clk_i);
  endtask

  // 32 valid beats at off from a cleared hunt counter; lock after the 32nd.
  task automatic hunt_lock(input logic [6:0] off, input logic [7:0] loss);
    for (int k = 1; k <= 32; k++) begin
      step(1'b1, 1'b1, off, good_hdr(k), (k == 32), off, 1'b0, loss);
    end
  endtask

  // 16 consecutive bad beats while locked, then the SLIP cycle.
  task automatic lose_lock(input logic [6:0] off, input logic [7:0] prev);
    logic [7:0] nxt;
    nxt = sat_inc(prev);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b1, off ^ 7'd1, bad_hdr(k), (k != 16), off, (k == 16), (k == 16) ? nxt : prev);
    end
    step(1'b1, 1'b0, off, 2'b01, 1'b0, off, 1'b0, nxt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] h;
    bus.en_i = 1'b0; bus.hdr_dv_i = 1'b0; bus.offset_i = '0; bus.header_i = '0;

    // Vector table: idle with enable low, enable, 32-beat acquisition with dv-low noise.
    tbl.push_back(mk(1'b0, 1'b0, 7'd0, 2'b01, 1'b0, 7'd0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b0, 1'b1, 7'd9, 2'b01, 1'b0, 7'd0, 1'b0, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 7'd0, 2'b00, 1'b0, 7'd0, 1'b1, 8'd0));
    tbl.push_back(mk(1'b1, 1'b0, 7'd0, 2'b00, 1'b0, 7'd0, 1'b0, 8'd0));
    for (int k = 1; k <= 32; k++) begin
      tbl.push_back(mk(1'b1, 1'b1, 7'd17, good_hdr(k), (k == 32), 7'd17, 1'b0, 8'd0));
      if (k == 10) tbl.push_back(mk(1'b1, 1'b0, 7'd5, 2'b11, 1'b0, 7'd17, 1'b0, 8'd0));
      if (k == 20) tbl.push_back(mk(1'b1, 1'b0, 7'd40, 2'b01, 1'b0, 7'd17, 1'b0, 8'd0));
    end
    tbl.push_back(mk(1'b1, 1'b0, 7'd0, 2'b00, 1'b1, 7'd17, 1'b0, 8'd0));

    // Asynchronous reset with no clock edge yet.
    #2 rst_i = 1'b1;
    #1 compare("reset_async", dut_out(), pack(1'b0, 7'd0, 1'b0, 8'd0));
    repeat (2) @(posedge clk_i);
    #1 compare("reset_hold", dut_out(), pack(1'b0, 7'd0, 1'b0, 8'd0));
    @(negedge clk_i);
    rst_i = 1'b0;

    cur_tag = "table_acquire";
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].dv, tbl[i].off, tbl[i].hdr,
           tbl[i].e_lock, tbl[i].e_off, tbl[i].e_resc, tbl[i].e_loss);
    end

    // Window 1: offset_i ignored, 15 bad early; window 2: 15 bad at the end.
    cur_tag = "window1";
    for (int w = 1; w <= 64; w++) begin
      h = (w >= 2 && w <= 16) ? bad_hdr(w) : good_hdr(w);
      step(1'b1, 1'b1, 7'd40, h, 1'b1, 7'd17, 1'b0, 8'd0);
    end
    cur_tag = "window2";
    for (int w = 1; w <= 64; w++) begin
      h = (w >= 50) ? bad_hdr(w) : good_hdr(w);
      step(1'b1, 1'b1, 7'd40, h, 1'b1, 7'd17, 1'b0, 8'd0);
    end
    // Window 3: 16th bad header lands on beat 64, coinciding with window end.
    cur_tag = "window3_loss";
    for (int w = 1; w <= 64; w++) begin
      h = (w >= 49) ? bad_hdr(w) : good_hdr(w);
      step(1'b1, 1'b1, 7'd40, h, (w != 64), 7'd17, (w == 64), (w == 64) ? 8'd1 : 8'd0);
    end
    cur_tag = "slip_discard";
    step(1'b1, 1'b1, 7'd40, 2'b01, 1'b0, 7'd17, 1'b0, 8'd1);

    cur_tag = "hunt_bad_restart";
    for (int k = 1; k <= 31; k++) step(1'b1, 1'b1, 7'd17, good_hdr(k), 1'b0, 7'd17, 1'b0, 8'd1);
    step(1'b1, 1'b1, 7'd17, 2'b11, 1'b0, 7'd17, 1'b0, 8'd1);
    for (int k = 1; k <= 31; k++) step(1'b1, 1'b1, 7'd17, good_hdr(k), 1'b0, 7'd17, 1'b0, 8'd1);
    step(1'b1, 1'b1, 7'd17, 2'b10, 1'b1, 7'd17, 1'b0, 8'd1);

    cur_tag = "enable_drop";
    step(1'b0, 1'b0, 7'd17, 2'b01, 1'b0, 7'd17, 1'b0, 8'd1);
    step(1'b1, 1'b0, 7'd17, 2'b01, 1'b0, 7'd17, 1'b1, 8'd1);

    cur_tag = "hunt_offset_change";
    for (int k = 1; k <= 20; k++) step(1'b1, 1'b1, 7'd17, good_hdr(k), 1'b0, 7'd17, 1'b0, 8'd1);
    for (int k = 1; k <= 32; k++) step(1'b1, 1'b1, 7'd40, good_hdr(k), (k == 32), 7'd40, 1'b0, 8'd1);

    cur_tag = "loss_to_three";
    lose_lock(7'd40, 8'd1);
    hunt_lock(7'd40, 8'd2);
    lose_lock(7'd40, 8'd2);
    hunt_lock(7'd40, 8'd3);

    // Reset while locked, mid-cycle, with enable held high throughout.
    @(negedge clk_i);
    bus.hdr_dv_i = 1'b0;
    #2 rst_i = 1'b1;
    #1 compare("reset_mid_async", dut_out(), pack(1'b0, 7'd0, 1'b0, 8'd0));
    @(posedge clk_i);
    #1 compare("reset_mid_hold", dut_out(), pack(1'b0, 7'd0, 1'b0, 8'd0));
    @(negedge clk_i);
    rst_i   = 1'b0;
    cur_tag = "reset_release_rescan";
    push_exp(1'b0, 7'd0, 1'b1, 8'd0);
    @(posedge clk_i);
    step(1'b1, 1'b0, 7'd0, 2'b00, 1'b0, 7'd0, 1'b0, 8'd0);

    cur_tag = "loss_saturation";
    for (int n = 1; n <= 256; n++) begin
      logic [7:0] prev;
      prev = (n - 1 > 255) ? 8'hFF : 8'(n - 1);
      hunt_lock(7'd0, prev);
      lose_lock(7'd0, prev);
    end

    repeat (2) @(posedge clk_i);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
